// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: streaming argmax over OUTPUT_NUM signed class scores.
// A running max/index is kept while the fully-connected layer streams its
// scores, and the frame result is registered one cycle after the last beat.
// Optional macro FC_ARGMAX_TOP2_EN adds runner-up class/score outputs.
module fc_argmax_classifier #(
  parameter int OUTPUT_NUM     = 10,
  parameter int SCORE_BITS     = 12,
  parameter int IDX_BITS       = 4,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_in,
  input  logic [SCORE_BITS-1:0]     data_in,
  input  logic                      clear,
  output logic [IDX_BITS-1:0]       class_out,
  output logic [SCORE_BITS-1:0]     score_out,
  output logic                      valid_out,
  output logic [FRAME_CNT_BITS-1:0] frame_cnt,
  output logic                      busy
`ifdef FC_ARGMAX_TOP2_EN
  ,
  output logic [IDX_BITS-1:0]       second_out,
  output logic [SCORE_BITS-1:0]     second_score_out
`endif
);

  typedef logic signed [SCORE_BITS-1:0] score_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(OUTPUT_NUM - 1);

  // beat counter doubles as the accumulate state: cnt==0 means idle/first beat
  logic [IDX_BITS-1:0]       cnt_q,   cnt_d;
  score_t                    max_q,   max_d;
  logic [IDX_BITS-1:0]       idx_q,   idx_d;
  logic [IDX_BITS-1:0]       class_q, class_d;
  logic [SCORE_BITS-1:0]     score_q, score_d;
  logic                      valid_q, valid_d;
  logic [FRAME_CNT_BITS-1:0] frame_q, frame_d;
  logic                      busy_q,  busy_d;

  score_t                    din;
  logic                      first_beat, last_beat, gt_max;
  score_t                    nxt_max;
  logic [IDX_BITS-1:0]       nxt_idx;

  assign din        = $signed(data_in);
  assign first_beat = (cnt_q == '0);
  assign last_beat  = (cnt_q == LAST_IDX);
  assign gt_max     = (din > max_q);

  // running max after this beat; the first beat of a frame always loads
  always_comb begin
    nxt_max = max_q;
    nxt_idx = idx_q;
    if (first_beat) begin
      nxt_max = din;
      nxt_idx = '0;
    end else if (gt_max) begin
      nxt_max = din;
      nxt_idx = cnt_q;
    end
  end

`ifdef FC_ARGMAX_TOP2_EN
  // runner-up tracking; sec_vld marks that the slot holds a real score
  score_t              sec_q,       sec_d;
  logic [IDX_BITS-1:0] sec_idx_q,   sec_idx_d;
  logic                sec_vld_q,   sec_vld_d;
  logic [IDX_BITS-1:0] sec_out_q,   sec_out_d;
  logic [SCORE_BITS-1:0] sec_scr_q, sec_scr_d;
  score_t              nxt_sec;
  logic [IDX_BITS-1:0] nxt_sec_idx;
  logic                nxt_sec_vld;

  // old max shifts down on a new max; otherwise fill an empty slot or beat it
  always_comb begin
    nxt_sec     = sec_q;
    nxt_sec_idx = sec_idx_q;
    nxt_sec_vld = sec_vld_q;
    if (first_beat) begin
      nxt_sec     = '0;
      nxt_sec_idx = '0;
      nxt_sec_vld = 1'b0;
    end else if (gt_max) begin
      nxt_sec     = max_q;
      nxt_sec_idx = idx_q;
      nxt_sec_vld = 1'b1;
    end else if (!sec_vld_q || (din > sec_q)) begin
      nxt_sec     = din;
      nxt_sec_idx = cnt_q;
      nxt_sec_vld = 1'b1;
    end
  end
`endif

  // frame sequencing: accept beats, abort on clear, publish on the last beat
  always_comb begin
    cnt_d   = cnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    class_d = class_q;
    score_d = score_q;
    valid_d = 1'b0;
    frame_d = frame_q;
`ifdef FC_ARGMAX_TOP2_EN
    sec_d     = sec_q;
    sec_idx_d = sec_idx_q;
    sec_vld_d = sec_vld_q;
    sec_out_d = sec_out_q;
    sec_scr_d = sec_scr_q;
`endif
    if (clear) begin
      // clear wins over a coincident beat, including the last one
      cnt_d = '0;
      max_d = '0;
      idx_d = '0;
`ifdef FC_ARGMAX_TOP2_EN
      sec_d     = '0;
      sec_idx_d = '0;
      sec_vld_d = 1'b0;
`endif
    end else if (valid_in) begin
      max_d = nxt_max;
      idx_d = nxt_idx;
`ifdef FC_ARGMAX_TOP2_EN
      sec_d     = nxt_sec;
      sec_idx_d = nxt_sec_idx;
      sec_vld_d = nxt_sec_vld;
`endif
      if (last_beat) begin
        cnt_d   = '0;
        class_d = nxt_idx;
        score_d = nxt_max;
        valid_d = 1'b1;
        frame_d = frame_q + FRAME_CNT_BITS'(1);
`ifdef FC_ARGMAX_TOP2_EN
        sec_out_d = nxt_sec_idx;
        sec_scr_d = nxt_sec;
`endif
      end else begin
        cnt_d = cnt_q + IDX_BITS'(1);
      end
    end
  end

  // registered busy so it tracks the counter without a decode on the output
  always_comb busy_d = (cnt_d != '0);

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      class_q <= '0;
      score_q <= '0;
      valid_q <= 1'b0;
      frame_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      class_q <= class_d;
      score_q <= score_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FC_ARGMAX_TOP2_EN
  // runner-up registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q     <= '0;
      sec_idx_q <= '0;
      sec_vld_q <= 1'b0;
      sec_out_q <= '0;
      sec_scr_q <= '0;
    end else begin
      sec_q     <= sec_d;
      sec_idx_q <= sec_idx_d;
      sec_vld_q <= sec_vld_d;
      sec_out_q <= sec_out_d;
      sec_scr_q <= sec_scr_d;
    end
  end

  assign second_out       = sec_out_q;
  assign second_score_out = sec_scr_q;
`endif

  assign class_out = class_q;
  assign score_out = score_q;
  assign valid_out = valid_q;
  assign frame_cnt = frame_q;
  assign busy      = busy_q;

endmodule
